nine_segment_frame_scheduler: RTL and testbench

- Sequences display patterns for the 3x3 nine-segment LED.
- Holds up to DEPTH frames in a small buffer, loaded over a valid/ready write port.
- Plays the frames in order, showing each for a programmable number of clocks, and wraps back to the first frame.
- Drives the 9-bit segments bus consumed by nine_segment_to_six_pin, which performs the row scan.

---
 rtl/nine_segment_frame_scheduler.sv | 122 ++++++++++++
 tb/tb_nine_segment_frame_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nine_segment_frame_scheduler.sv
// Frame buffer and dwell sequencer for the 3x3 nine-segment LED.
// Plays stored patterns in rotation; the row scan is done downstream.
module nine_segment_frame_scheduler #(
    parameter int DEPTH   = 4,
    parameter int DWELL_W = 16,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [8:0]         wr_data,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               enable,
    input  logic               clear,
    output logic [8:0]         segments,
    output logic [IDX_W-1:0]   frame_idx,
    output logic [IDX_W:0]     frame_count,
    output logic               frame_strobe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [8:0]         fbuf [DEPTH];
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_d, idx_nxt;
    logic [IDX_W:0]     count_d;
    logic [8:0]         seg_d;
    logic               strobe_d;
    logic               accept;
    logic [DWELL_W-1:0] dwell_ld;

    assign wr_ready = (frame_count < (IDX_W+1)'(DEPTH)) && !clear;
    assign accept   = wr_valid && wr_ready;

    // A zero dwell behaves like one clock per frame.
    assign dwell_ld = (dwell == '0) ? '0 : dwell - 1'b1;

    assign idx_nxt = (({1'b0, frame_idx} + 1'b1) == frame_count)
                   ? '0 : frame_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (accept)
            fbuf[frame_count[IDX_W-1:0]] <= wr_data;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = frame_idx;
        cnt_d    = cnt_q;
        seg_d    = segments;
        strobe_d = 1'b0;
        count_d  = frame_count + (IDX_W+1)'(accept);
        if (clear) begin
            state_d = IDLE;
            idx_d   = '0;
            seg_d   = '0;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    seg_d = '0;
                    if (enable && frame_count != '0) begin
                        state_d = SHOW;
                        idx_d   = '0;
                        seg_d   = fbuf[0];
                        cnt_d   = dwell_ld;
                    end
                end
                SHOW: begin
                    if (!enable) begin
                        state_d = PAUSE;
                        seg_d   = '0;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        idx_d    = idx_nxt;
                        seg_d    = fbuf[idx_nxt];
                        cnt_d    = dwell_ld;
                        strobe_d = 1'b1;
                    end
                end
                PAUSE: begin
                    seg_d = '0;
                    // Resume keeps the held count so the frame finishes its dwell.
                    if (enable) begin
                        state_d = SHOW;
                        seg_d   = fbuf[frame_idx];
                    end
                end
                default: begin
                    state_d = IDLE;
                    seg_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            frame_idx    <= '0;
            cnt_q        <= '0;
            segments     <= '0;
            frame_strobe <= 1'b0;
            frame_count  <= '0;
        end else begin
            state_q      <= state_d;
            frame_idx    <= idx_d;
            cnt_q        <= cnt_d;
            segments     <= seg_d;
            frame_strobe <= strobe_d;
            frame_count  <= count_d;
        end
    end

endmodule

// File: tb/tb_nine_segment_frame_scheduler.sv
// Randomized bench for nine_segment_frame_scheduler against a
// frame-list reference model.
module tb_nine_segment_frame_scheduler;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [8:0]  wr_data;
    logic [15:0] dwell;
    logic        enable;
    logic        clear;
    logic [8:0]  segments;
    logic [1:0]  frame_idx;
    logic [2:0]  frame_count;
    logic        frame_strobe;

    int total = 0;
    int bad   = 0;

    logic [8:0] mq [$];
    int         midx, mleft, mmode;
    logic [8:0] mseg;
    logic       mstrobe;

    nine_segment_frame_scheduler #(.DEPTH(DEPTH), .DWELL_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .dwell(dwell), .enable(enable), .clear(clear),
        .segments(segments), .frame_idx(frame_idx),
        .frame_count(frame_count), .frame_strobe(frame_strobe)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_vec();
        logic [1:0] i;
        logic [2:0] c;
        logic       r;
        i = midx[1:0];
        c = 3'(mq.size());
        r = (mq.size() < DEPTH) && !clear;
        return {mseg, i, c, mstrobe, r};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {segments, frame_idx, frame_count, frame_strobe, wr_ready};
    endfunction

    task automatic model_reset();
        mq.delete();
        midx = 0; mleft = 1; mmode = 0;
        mseg = '0; mstrobe = 1'b0;
    endtask

    // mode 0 = idle, 1 = showing, 2 = paused; mleft = clocks left on frame
    task automatic model_edge();
        bit acc;
        int d;
        d = (dwell == 0) ? 1 : int'(dwell);
        if (clear) begin
            model_reset();
            return;
        end
        acc = wr_valid && (mq.size() < DEPTH);
        mstrobe = 1'b0;
        case (mmode)
            0: begin
                mseg = '0;
                if (enable && mq.size() > 0) begin
                    mmode = 1; midx = 0; mseg = mq[0]; mleft = d;
                end
            end
            1: begin
                if (!enable) begin
                    mmode = 2; mseg = '0;
                end else if (mleft > 1) begin
                    mleft--;
                end else begin
                    midx = (midx + 1) % mq.size();
                    mseg = mq[midx]; mleft = d; mstrobe = 1'b1;
                end
            end
            default: begin
                mseg = '0;
                if (enable) begin
                    mmode = 1; mseg = mq[midx];
                end
            end
        endcase
        if (acc) mq.push_back(wr_data);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid = 0; wr_data = '0; clear = 0;
    endtask

    task automatic flush();
        idle_inputs();
        enable = 0; clear = 1;
        step();
        clear = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs(); enable = 0; dwell = 3;
        model_reset();
        #2;
        total++;
        if (dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset: got %h want %h", dut_vec(), exp_vec());
        end
        #10 rst_n = 1;
    endtask

    task automatic test_rotation();
        flush();
        dwell = 3; enable = 1;
        wr_valid = 1; wr_data = 9'h010;
        step();
        wr_data = 9'h1FF;
        step();
        total++;
        if (segments !== 9'h010) begin
            bad++;
            $display("FAIL rot_first: got %h want 010", segments);
        end
        idle_inputs();
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL rot[%0d]: got %h want %h",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_full();
        logic [8:0] pats [4] = '{9'h001, 9'h002, 9'h004, 9'h008};
        flush();
        dwell = 2; enable = 1;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1; wr_data = pats[i];
            step();
        end
        wr_data = 9'h100;
        for (int i = 0; i < 16; i++) begin
            step();
            total++;
            if (dut_vec() !== exp_vec() || segments === 9'h100) begin
                bad++;
                $display("FAIL full[%0d]: got %h want %h",
                         i, dut_vec(), exp_vec());
            end
        end
        total++;
        if (wr_ready !== 1'b0 || frame_count !== 3'd4) begin
            bad++;
            $display("FAIL full_flags: got rdy=%b cnt=%0d want 0/4",
                     wr_ready, frame_count);
        end
        idle_inputs();
    endtask

    task automatic test_pause();
        int n;
        flush();
        dwell = 6; enable = 0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1; wr_data = 9'($urandom_range(1, 511));
            step();
        end
        idle_inputs();
        enable = 1;
        n = 0;
        while (!(midx == 1 && mstrobe) && n < 40) begin
            step(); n++;
        end
        total++;
        if (n >= 40 || frame_idx !== 2'd1) begin
            bad++;
            $display("FAIL pause_reach: idx=%0d want 1", frame_idx);
        end
        step(); step();
        enable = 0;
        for (int i = 0; i < 11; i++) begin
            step();
            total++;
            if (dut_vec() !== exp_vec() || segments !== 9'h000
                || frame_idx !== 2'd1) begin
                bad++;
                $display("FAIL paused[%0d]: got %h want %h",
                         i, dut_vec(), exp_vec());
            end
        end
        enable = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL resume[%0d]: got %h want %h",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_clear_vs_write();
        flush();
        dwell = 2; enable = 1;
        wr_valid = 1; wr_data = 9'h033; step();
        wr_data = 9'h1C0; step();
        idle_inputs();
        for (int i = 0; i < 5; i++) step();
        clear = 1; wr_valid = 1; wr_data = 9'h0AA;
        #1;
        total++;
        if (wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL clr_ready: got %b want 0", wr_ready);
        end
        step();
        total++;
        if (dut_vec() !== exp_vec() || frame_count !== 3'd0
            || segments !== 9'h000) begin
            bad++;
            $display("FAIL clr: got %h want %h", dut_vec(), exp_vec());
        end
        idle_inputs();
        wr_valid = 1; wr_data = 9'h055; step();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (dut_vec() !== exp_vec() || segments === 9'h0AA) begin
                bad++;
                $display("FAIL clr_after[%0d]: got %h want %h",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_dwell0();
        flush();
        dwell = 0; enable = 0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1; wr_data = 9'($urandom_range(0, 511));
            step();
        end
        idle_inputs();
        enable = 1;
        step(); step();
        for (int i = 0; i < 9; i++) begin
            step();
            total++;
            if (dut_vec() !== exp_vec() || frame_strobe !== 1'b1) begin
                bad++;
                $display("FAIL dwell0[%0d]: got %h want %h",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        flush();
        dwell = 3; enable = 1;
        wr_valid = 1; wr_data = 9'h1EE; step();
        idle_inputs();
        for (int i = 0; i < 4; i++) step();
        #2 rst_n = 0;
        model_reset();
        #1;
        total++;
        if (dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL rst_mid: got %h want %h", dut_vec(), exp_vec());
        end
        #1 rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (dut_vec() !== exp_vec() || segments !== 9'h000) begin
                bad++;
                $display("FAIL rst_quiet[%0d]: got %h want %h",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        flush();
        for (int i = 0; i < 600; i++) begin
            wr_valid = ($urandom_range(0, 9) < 3);
            wr_data  = 9'($urandom_range(0, 511));
            clear    = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            if ($urandom_range(0, 15) == 0) dwell = 16'($urandom_range(0, 4));
            #1;
            total++;
            if (wr_ready !== exp_vec()[0]) begin
                bad++;
                $display("FAIL rnd_ready[%0d]: got %b want %b",
                         i, wr_ready, exp_vec()[0]);
            end
            step();
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL rnd[%0d]: got %h want %h",
                         i, dut_vec(), exp_vec());
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_full();
        test_pause();
        test_clear_vs_write();
        test_dwell0();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
